// File: rtl/spu_issue_scoreboard.sv
// Dual-issue scoreboard and in-order issue controller for the SPU decode stage.
// Tracks in-flight register writes with per-register countdowns and issues a decoded pair dual, split or stalled.
module spu_issue_scoreboard #(
    parameter int unsigned NUM_REGS = 128,
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned LAT_W    = 4,
    parameter int unsigned MAX_LAT  = 7,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              s0_pipe,
    input  logic              s0_wr,
    input  logic [ADDR_W-1:0] s0_dst,
    input  logic [LAT_W-1:0]  s0_lat,
    input  logic [ADDR_W-1:0] s0_ra,
    input  logic [ADDR_W-1:0] s0_rb,
    input  logic [ADDR_W-1:0] s0_rc,
    input  logic              s0_ra_en,
    input  logic              s0_rb_en,
    input  logic              s0_rc_en,
    input  logic              s1_pipe,
    input  logic              s1_wr,
    input  logic [ADDR_W-1:0] s1_dst,
    input  logic [LAT_W-1:0]  s1_lat,
    input  logic [ADDR_W-1:0] s1_ra,
    input  logic [ADDR_W-1:0] s1_rb,
    input  logic [ADDR_W-1:0] s1_rc,
    input  logic              s1_ra_en,
    input  logic              s1_rb_en,
    input  logic              s1_rc_en,
    output logic              even_vld,
    output logic              odd_vld,
    output logic              even_slot,
    output logic              odd_slot,
    output logic [ADDR_W-1:0] even_dst,
    output logic [ADDR_W-1:0] odd_dst,
    output logic              even_wr,
    output logic              odd_wr,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LAT_W-1:0]  busy [NUM_REGS];
    logic [LAT_W-1:0]  sat0;
    logic [LAT_W-1:0]  sat1;
    logic              s0_ok;
    logic              s1_ok;
    logic              s1_dep;
    logic              go0;
    logic              go1;
    logic              ld0;
    logic              ld1;
    logic              stall_inc;
    logic              e_vld;
    logic              e_slot;
    logic              e_wr;
    logic [ADDR_W-1:0] e_dst;
    logic              o_vld;
    logic              o_slot;
    logic              o_wr;
    logic [ADDR_W-1:0] o_dst;

    // Per-slot readiness: a source whose countdown is on its last count is
    // forwarded in time, so a dependent may issue L cycles after its producer.
    always_comb begin
        sat0  = (s0_lat > LAT_MAX) ? LAT_MAX : s0_lat;
        sat1  = (s1_lat > LAT_MAX) ? LAT_MAX : s1_lat;
        s0_ok = (!s0_ra_en || busy[s0_ra] <= LAT_ONE) &&
                (!s0_rb_en || busy[s0_rb] <= LAT_ONE) &&
                (!s0_rc_en || busy[s0_rc] <= LAT_ONE) &&
                !(s0_wr && busy[s0_dst] > sat0);
        s1_ok = (!s1_ra_en || busy[s1_ra] <= LAT_ONE) &&
                (!s1_rb_en || busy[s1_rb] <= LAT_ONE) &&
                (!s1_rc_en || busy[s1_rc] <= LAT_ONE) &&
                !(s1_wr && busy[s1_dst] > sat1);
        s1_dep = s0_wr && ((s1_ra_en && s1_ra == s0_dst) ||
                           (s1_rb_en && s1_rb == s0_dst) ||
                           (s1_rc_en && s1_rc == s0_dst) ||
                           (s1_wr && s1_dst == s0_dst));
    end

    // Issue decision and next state; flush suppresses all issue.
    always_comb begin
        go0       = 1'b0;
        go1       = 1'b0;
        in_ready  = 1'b0;
        state_nxt = state;
        if (in_valid && !flush) begin
            case (state)
                PAIR: begin
                    go0 = s0_ok;
                    go1 = s0_ok && (s1_pipe != s0_pipe) && s1_ok && !s1_dep;
                    in_ready = go1;
                    if (go0 && !go1) begin
                        state_nxt = SECOND;
                    end
                end
                SECOND: begin
                    go1      = s1_ok;
                    in_ready = s1_ok;
                    if (s1_ok) begin
                        state_nxt = PAIR;
                    end
                end
                default: state_nxt = PAIR;
            endcase
        end
        if (flush) begin
            state_nxt = PAIR;
        end
        ld0       = go0 && s0_wr && (sat0 != '0);
        ld1       = go1 && s1_wr && (sat1 != '0);
        stall_inc = in_valid && !flush && !go0 && !go1;
    end

    // Route issued slots to their pipes; the two slots never share a pipe in one cycle.
    always_comb begin
        e_slot = go1 && !s1_pipe;
        e_vld  = (go0 && !s0_pipe) || e_slot;
        e_wr   = e_slot ? s1_wr  : (go0 && !s0_pipe && s0_wr);
        e_dst  = e_slot ? s1_dst : ((go0 && !s0_pipe) ? s0_dst : '0);
        o_slot = go1 && s1_pipe;
        o_vld  = (go0 && s0_pipe) || o_slot;
        o_wr   = o_slot ? s1_wr  : (go0 && s0_pipe && s0_wr);
        o_dst  = o_slot ? s1_dst : ((go0 && s0_pipe) ? s0_dst : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PAIR;
            even_vld    <= 1'b0;
            odd_vld     <= 1'b0;
            even_slot   <= 1'b0;
            odd_slot    <= 1'b0;
            even_dst    <= '0;
            odd_dst     <= '0;
            even_wr     <= 1'b0;
            odd_wr      <= 1'b0;
            stall_count <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                busy[r] <= '0;
            end
        end else begin
            state     <= state_nxt;
            even_vld  <= e_vld;
            odd_vld   <= o_vld;
            even_slot <= e_slot;
            odd_slot  <= o_slot;
            even_dst  <= e_dst;
            odd_dst   <= o_dst;
            even_wr   <= e_wr;
            odd_wr    <= o_wr;
            if (stall_inc) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            // A new write load takes precedence over the running countdown.
            for (int r = 0; r < NUM_REGS; r++) begin
                if (ld0 && s0_dst == ADDR_W'(r)) begin
                    busy[r] <= sat0;
                end else if (ld1 && s1_dst == ADDR_W'(r)) begin
                    busy[r] <= sat1;
                end else if (busy[r] != '0) begin
                    busy[r] <= busy[r] - LAT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_spu_issue_scoreboard.sv
// Directed self-checking bench for spu_issue_scoreboard: dual/split issue, RAW/WAW stalls, flush, saturation, reset.
module tb_spu_issue_scoreboard;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       s0_pipe, s0_wr, s0_ra_en, s0_rb_en, s0_rc_en;
    logic       s1_pipe, s1_wr, s1_ra_en, s1_rb_en, s1_rc_en;
    logic [6:0] s0_dst, s0_ra, s0_rb, s0_rc;
    logic [6:0] s1_dst, s1_ra, s1_rb, s1_rc;
    logic [3:0] s0_lat, s1_lat;
    logic       even_vld, odd_vld, even_slot, odd_slot, even_wr, odd_wr;
    logic [6:0] even_dst, odd_dst;
    logic [31:0] stall_count;

    int n_pass;
    int n_total;

    spu_issue_scoreboard dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .s0_pipe(s0_pipe), .s0_wr(s0_wr), .s0_dst(s0_dst), .s0_lat(s0_lat),
        .s0_ra(s0_ra), .s0_rb(s0_rb), .s0_rc(s0_rc),
        .s0_ra_en(s0_ra_en), .s0_rb_en(s0_rb_en), .s0_rc_en(s0_rc_en),
        .s1_pipe(s1_pipe), .s1_wr(s1_wr), .s1_dst(s1_dst), .s1_lat(s1_lat),
        .s1_ra(s1_ra), .s1_rb(s1_rb), .s1_rc(s1_rc),
        .s1_ra_en(s1_ra_en), .s1_rb_en(s1_rb_en), .s1_rc_en(s1_rc_en),
        .even_vld(even_vld), .odd_vld(odd_vld), .even_slot(even_slot), .odd_slot(odd_slot),
        .even_dst(even_dst), .odd_dst(odd_dst), .even_wr(even_wr), .odd_wr(odd_wr),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        flush = 0; in_valid = 0;
        s0_pipe = 0; s0_wr = 0; s0_dst = 0; s0_lat = 0; s0_ra = 0; s0_rb = 0; s0_rc = 0;
        s0_ra_en = 0; s0_rb_en = 0; s0_rc_en = 0;
        s1_pipe = 0; s1_wr = 0; s1_dst = 0; s1_lat = 0; s1_ra = 0; s1_rb = 0; s1_rc = 0;
        s1_ra_en = 0; s1_rb_en = 0; s1_rc_en = 0;
    endtask

    task automatic idle(input int n);
        clr_in();
        repeat (n) step();
    endtask

    task automatic test_reset();
        n_total++;
        if ({even_vld, odd_vld, even_slot, odd_slot, even_wr, odd_wr} !== 6'b0 ||
            even_dst !== 7'd0 || odd_dst !== 7'd0) begin
            $display("FAIL reset_outputs: got vld=%b/%b dst=%0d/%0d, want all zero",
                     even_vld, odd_vld, even_dst, odd_dst);
        end else n_pass++;
        n_total++;
        if (stall_count !== 32'd0) $display("FAIL reset_stall: got %0d want 0", stall_count);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else n_pass++;
    endtask

    task automatic test_dual();
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd1; s0_lat = 4'd3;
        s1_pipe = 1; s1_wr = 1; s1_dst = 7'd2; s1_lat = 4'd2;
        in_valid = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL dual_in_ready: got %b want 1", in_ready);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (even_vld !== 1'b1 || odd_vld !== 1'b1 || even_slot !== 1'b0 || odd_slot !== 1'b1)
            $display("FAIL dual_issue: got vld=%b%b slot=%b%b want 11 01", even_vld, odd_vld, even_slot, odd_slot);
        else n_pass++;
        n_total++;
        if (even_dst !== 7'd1 || odd_dst !== 7'd2 || even_wr !== 1'b1 || odd_wr !== 1'b1)
            $display("FAIL dual_dst: got %0d/%0d wr=%b%b want 1/2 wr=11", even_dst, odd_dst, even_wr, odd_wr);
        else n_pass++;
        n_total++;
        if (stall_count !== 32'd0) $display("FAIL dual_stall: got %0d want 0", stall_count);
        else n_pass++;
        step();
        n_total++;
        if (even_vld !== 1'b0 || odd_vld !== 1'b0)
            $display("FAIL dual_one_cycle: got vld=%b%b want 00", even_vld, odd_vld);
        else n_pass++;
        idle(8);
    endtask

    task automatic test_same_pipe();
        logic [31:0] sc0;
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd3; s0_lat = 4'd1;
        s1_pipe = 0; s1_wr = 1; s1_dst = 7'd4; s1_lat = 4'd1;
        in_valid = 1;
        sc0 = stall_count;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL same_pipe_first_ready: got %b want 0", in_ready);
        else n_pass++;
        step();
        n_total++;
        if (even_vld !== 1'b1 || even_slot !== 1'b0 || even_dst !== 7'd3 || odd_vld !== 1'b0)
            $display("FAIL same_pipe_cycle1: got even_vld=%b slot=%b dst=%0d odd_vld=%b want 1 0 3 0",
                     even_vld, even_slot, even_dst, odd_vld);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL same_pipe_second_ready: got %b want 1", in_ready);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (even_vld !== 1'b1 || even_slot !== 1'b1 || even_dst !== 7'd4 || odd_vld !== 1'b0)
            $display("FAIL same_pipe_cycle2: got even_vld=%b slot=%b dst=%0d odd_vld=%b want 1 1 4 0",
                     even_vld, even_slot, even_dst, odd_vld);
        else n_pass++;
        n_total++;
        if (stall_count !== sc0) $display("FAIL same_pipe_stall: got %0d want %0d", stall_count, sc0);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_raw();
        logic [31:0] sc0;
        int n;
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd5; s0_lat = 4'd6;
        s1_pipe = 1; s1_wr = 0; s1_ra = 7'd5; s1_ra_en = 1;
        in_valid = 1;
        sc0 = stall_count;
        step();
        n_total++;
        if (even_vld !== 1'b1 || even_dst !== 7'd5)
            $display("FAIL raw_slot0: got even_vld=%b dst=%0d want 1 5", even_vld, even_dst);
        else n_pass++;
        n = 1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        n_total++;
        if (n != 6) $display("FAIL raw_latency: got slot1 at t+%0d want t+6", n);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (odd_vld !== 1'b1 || odd_slot !== 1'b1 || even_vld !== 1'b0)
            $display("FAIL raw_slot1: got odd_vld=%b slot=%b even_vld=%b want 1 1 0", odd_vld, odd_slot, even_vld);
        else n_pass++;
        n_total++;
        if (stall_count - sc0 !== 32'd5) $display("FAIL raw_stall: got +%0d want +5", stall_count - sc0);
        else n_pass++;
        idle(8);
    endtask

    task automatic test_waw();
        logic [31:0] sc0;
        int n;
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd10; s0_lat = 4'd4;
        s1_pipe = 1;
        in_valid = 1;
        step();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd10; s0_lat = 4'd2;
        s1_pipe = 1; s1_wr = 1; s1_dst = 7'd11; s1_lat = 4'd1;
        sc0 = stall_count;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        n_total++;
        if (n != 2) $display("FAIL waw_block: got %0d blocked cycles want 2", n);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (even_vld !== 1'b1 || even_dst !== 7'd10 || odd_vld !== 1'b1 || odd_dst !== 7'd11)
            $display("FAIL waw_issue: got vld=%b%b dst=%0d/%0d want 11 10/11", even_vld, odd_vld, even_dst, odd_dst);
        else n_pass++;
        n_total++;
        if (stall_count - sc0 !== 32'd2) $display("FAIL waw_stall: got +%0d want +2", stall_count - sc0);
        else n_pass++;
        idle(8);
    endtask

    task automatic test_flush();
        logic [31:0] sc0;
        int n;
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd20; s0_lat = 4'd5;
        s1_pipe = 0; s1_wr = 1; s1_dst = 7'd21; s1_lat = 4'd1;
        in_valid = 1;
        step();
        n_total++;
        if (even_vld !== 1'b1 || even_slot !== 1'b0)
            $display("FAIL flush_setup: got even_vld=%b slot=%b want 1 0", even_vld, even_slot);
        else n_pass++;
        flush = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready);
        else n_pass++;
        sc0 = stall_count;
        step();
        clr_in();
        n_total++;
        if (even_vld !== 1'b0 || odd_vld !== 1'b0)
            $display("FAIL flush_no_issue: got vld=%b%b want 00", even_vld, odd_vld);
        else n_pass++;
        n_total++;
        if (stall_count !== sc0) $display("FAIL flush_stall: got %0d want %0d", stall_count, sc0);
        else n_pass++;
        // r20 was loaded with 5 two cycles ago and must still be counting down
        s0_pipe = 0; s0_ra = 7'd20; s0_ra_en = 1;
        s1_pipe = 1; s1_wr = 1; s1_dst = 7'd22; s1_lat = 4'd1;
        in_valid = 1;
        #1;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        n_total++;
        if (n != 3) $display("FAIL flush_busy_kept: got %0d blocked cycles want 3", n);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (even_vld !== 1'b1 || even_slot !== 1'b0 || odd_vld !== 1'b1 || odd_slot !== 1'b1)
            $display("FAIL flush_state_pair: got vld=%b%b slot=%b%b want 11 01", even_vld, odd_vld, even_slot, odd_slot);
        else n_pass++;
        idle(8);
    endtask

    task automatic test_saturate();
        logic [31:0] sc0;
        int n;
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd30; s0_lat = 4'd12;
        s1_pipe = 1; s1_wr = 1; s1_dst = 7'd31; s1_lat = 4'd1; s1_rc = 7'd30; s1_rc_en = 1;
        in_valid = 1;
        sc0 = stall_count;
        step();
        n = 1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        n_total++;
        if (n != 7) $display("FAIL sat_latency: got slot1 at t+%0d want t+7", n);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (odd_vld !== 1'b1 || odd_dst !== 7'd31 || odd_wr !== 1'b1)
            $display("FAIL sat_issue: got odd_vld=%b dst=%0d wr=%b want 1 31 1", odd_vld, odd_dst, odd_wr);
        else n_pass++;
        n_total++;
        if (stall_count - sc0 !== 32'd6) $display("FAIL sat_stall: got +%0d want +6", stall_count - sc0);
        else n_pass++;
        idle(10);
    endtask

    task automatic test_back_to_back();
        logic [31:0] sc0;
        logic [6:0]  d0;
        logic [6:0]  d1;
        sc0 = stall_count;
        for (int i = 0; i < 3; i++) begin
            clr_in();
            d0 = 7'(40 + 2 * i);
            d1 = 7'(41 + 2 * i);
            s0_pipe = (i == 1); s0_wr = 1; s0_dst = d0; s0_lat = 4'd2;
            s1_pipe = (i != 1); s1_wr = 1; s1_dst = d1; s1_lat = 4'd3;
            in_valid = 1;
            #1;
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, in_ready);
            else n_pass++;
            step();
            n_total++;
            if (i == 1) begin
                if (odd_dst !== d0 || odd_slot !== 1'b0 || even_dst !== d1 || even_slot !== 1'b1)
                    $display("FAIL b2b_issue_%0d: got even %0d/%b odd %0d/%b want even %0d/1 odd %0d/0",
                             i, even_dst, even_slot, odd_dst, odd_slot, d1, d0);
                else n_pass++;
            end else begin
                if (even_dst !== d0 || even_slot !== 1'b0 || odd_dst !== d1 || odd_slot !== 1'b1)
                    $display("FAIL b2b_issue_%0d: got even %0d/%b odd %0d/%b want even %0d/0 odd %0d/1",
                             i, even_dst, even_slot, odd_dst, odd_slot, d0, d1);
                else n_pass++;
            end
        end
        clr_in();
        n_total++;
        if (stall_count !== sc0) $display("FAIL b2b_stall: got %0d want %0d", stall_count, sc0);
        else n_pass++;
        idle(6);
    endtask

    task automatic test_intra_pair();
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd50; s0_lat = 4'd1;
        s1_pipe = 1; s1_wr = 0; s1_ra = 7'd50; s1_ra_en = 1;
        in_valid = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL intra_raw_split: got in_ready=%b want 0", in_ready);
        else n_pass++;
        step();
        n_total++;
        if (in_ready !== 1'b1 || odd_vld !== 1'b0)
            $display("FAIL intra_raw_second: got in_ready=%b odd_vld=%b want 1 0", in_ready, odd_vld);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (odd_vld !== 1'b1 || odd_slot !== 1'b1) $display("FAIL intra_raw_issue: got odd_vld=%b slot=%b want 1 1", odd_vld, odd_slot);
        else n_pass++;
        idle(3);
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd52; s0_lat = 4'd2;
        s1_pipe = 1; s1_wr = 1; s1_dst = 7'd52; s1_lat = 4'd2;
        in_valid = 1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL intra_same_dst: got in_ready=%b want 0", in_ready);
        else n_pass++;
        step();
        step();
        clr_in();
        n_total++;
        if (odd_vld !== 1'b1 || odd_dst !== 7'd52) $display("FAIL intra_same_dst_issue: got odd_vld=%b dst=%0d want 1 52", odd_vld, odd_dst);
        else n_pass++;
        idle(4);
        // lat=0 writes leave the scoreboard idle, so a rewrite is never WAW-blocked
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd60; s0_lat = 4'd0;
        s1_pipe = 1;
        in_valid = 1;
        step();
        s0_lat = 4'd0;
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL lat_zero: got in_ready=%b want 1", in_ready);
        else n_pass++;
        step();
        clr_in();
        idle(3);
    endtask

    task automatic test_reset_mid_second();
        clr_in();
        s0_pipe = 0; s0_wr = 1; s0_dst = 7'd70; s0_lat = 4'd1;
        s1_pipe = 0; s1_wr = 1; s1_dst = 7'd71; s1_lat = 4'd1;
        in_valid = 1;
        step();
        rst = 1;
        #1;
        n_total++;
        if (even_vld !== 1'b0 || stall_count !== 32'd0)
            $display("FAIL rst_async: got even_vld=%b stall=%0d want 0 0", even_vld, stall_count);
        else n_pass++;
        #1;
        rst = 0;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL rst_state_pair_ready: got %b want 0", in_ready);
        else n_pass++;
        step();
        clr_in();
        n_total++;
        if (even_vld !== 1'b1 || even_slot !== 1'b0 || even_dst !== 7'd70)
            $display("FAIL rst_state_pair: got even_vld=%b slot=%b dst=%0d want 1 0 70", even_vld, even_slot, even_dst);
        else n_pass++;
        idle(3);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1;
        clr_in();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 0;
        step();
        test_dual();
        test_same_pipe();
        test_raw();
        test_waw();
        test_flush();
        test_saturate();
        test_back_to_back();
        test_intra_pair();
        test_reset_mid_second();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
